// File: rtl/cu_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, T-step encoding,
// the datapath control vector and the per-opcode final step.
package cu_pkg;

   // Opcode field IR[31:27]
   localparam logic [4:0] OpLd   = 5'd0;
   localparam logic [4:0] OpLdi  = 5'd1;
   localparam logic [4:0] OpSt   = 5'd2;
   localparam logic [4:0] OpAdd  = 5'd3;
   localparam logic [4:0] OpSub  = 5'd4;
   localparam logic [4:0] OpAnd  = 5'd5;
   localparam logic [4:0] OpOr   = 5'd6;
   localparam logic [4:0] OpAddi = 5'd12;
   localparam logic [4:0] OpNop  = 5'd26;
   localparam logic [4:0] OpHalt = 5'd27;

   // T-steps are consecutive so the sequencer can simply increment.
   typedef enum logic [3:0] {
      StT0   = 4'd0,
      StT1   = 4'd1,
      StT2   = 4'd2,
      StT3   = 4'd3,
      StT4   = 4'd4,
      StT5   = 4'd5,
      StT6   = 4'd6,
      StT7   = 4'd7,
      StHalt = 4'd8
   } cu_state_e;

   typedef struct packed {
      logic pc_out;
      logic pc_in;
      logic inc_pc;
      logic mar_in;
      logic mdr_in;
      logic mdr_out;
      logic ir_in;
      logic read;
      logic write;
      logic y_in;
      logic z_in;
      logic zlow_out;
      logic c_out;
      logic ba_out;
      logic gra;
      logic grb;
      logic grc;
      logic r_in;
      logic r_out;
      logic alu_add;
      logic alu_sub;
      logic alu_and;
      logic alu_or;
   } cu_ctrl_t;

   // Final T-step of each instruction; nop, halt and undefined opcodes end at T2.
   function automatic cu_state_e last_step(input logic [4:0] op);
      cu_state_e st;
      case (op)
         OpLd:                                   st = StT7;
         OpSt:                                   st = StT6;
         OpLdi, OpAdd, OpSub, OpAnd, OpOr, OpAddi: st = StT5;
         default:                                st = StT2;
      endcase
      return st;
   endfunction

endpackage

// File: rtl/cu_step_decode.sv
// Combinational decode of (T-step, opcode) into the datapath control vector.
module cu_step_decode
   import cu_pkg::*;
(
   input  cu_state_e  state,
   input  logic [4:0] ir_op,
   output cu_ctrl_t   ctrl
);

   // Fetch steps ignore the opcode; execute steps select on it.
   always_comb begin
      ctrl = '0;
      unique case (state)
         StT0: begin
            ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1; ctrl.inc_pc = 1'b1; ctrl.z_in = 1'b1;
         end
         StT1: begin
            ctrl.zlow_out = 1'b1; ctrl.pc_in = 1'b1; ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
         end
         StT2: begin
            ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1;
         end
         StT3: begin
            case (ir_op)
               OpLd, OpLdi, OpSt: begin
                  ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1;
               end
               OpAdd, OpSub, OpAnd, OpOr, OpAddi: begin
                  ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1;
               end
               default: ;
            endcase
         end
         StT4: begin
            case (ir_op)
               OpLd, OpLdi, OpSt, OpAddi: begin
                  ctrl.c_out = 1'b1; ctrl.alu_add = 1'b1; ctrl.z_in = 1'b1;
               end
               OpAdd, OpSub, OpAnd, OpOr: begin
                  ctrl.grc    = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1;
                  ctrl.alu_add = (ir_op == OpAdd);
                  ctrl.alu_sub = (ir_op == OpSub);
                  ctrl.alu_and = (ir_op == OpAnd);
                  ctrl.alu_or  = (ir_op == OpOr);
               end
               default: ;
            endcase
         end
         StT5: begin
            case (ir_op)
               OpLd, OpSt: begin
                  ctrl.zlow_out = 1'b1; ctrl.mar_in = 1'b1;
               end
               OpLdi, OpAdd, OpSub, OpAnd, OpOr, OpAddi: begin
                  ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
               end
               default: ;
            endcase
         end
         StT6: begin
            if (ir_op == OpSt) begin
               ctrl.write = 1'b1; ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.mdr_in = 1'b1;
            end else if (ir_op == OpLd) begin
               ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
            end
         end
         StT7: begin
            if (ir_op == OpLd) begin
               ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore control unit: T-step sequencer with HALT state.
// Optional feature macro CU_MEM_WAIT_EN: steps driving Read or Write stall until mem_done.
module control_unit
   import cu_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] ir_op,
   input  logic       stop,
   input  logic       mem_done,
   output logic       PCout,
   output logic       PCin,
   output logic       IncPC,
   output logic       MARin,
   output logic       MDRin,
   output logic       MDRout,
   output logic       IRin,
   output logic       Read,
   output logic       Write,
   output logic       Yin,
   output logic       Zin,
   output logic       Zlowout,
   output logic       Cout,
   output logic       BAout,
   output logic       Gra,
   output logic       Grb,
   output logic       Grc,
   output logic       Rin,
   output logic       Rout,
   output logic       ADD,
   output logic       SUB,
   output logic       AND,
   output logic       OR,
   output logic       run
);

   cu_state_e state_q, state_d;
   cu_ctrl_t  ctrl_dec, ctrl;
   logic      stall;

   cu_step_decode u_decode (
      .state (state_q),
      .ir_op (ir_op),
      .ctrl  (ctrl_dec)
   );

   // Reset is synchronous, so the state may still be stale while it is held; gate it here.
   assign ctrl = reset ? '0 : ctrl_dec;
   assign run  = ~reset & (state_q != StHalt);

`ifdef CU_MEM_WAIT_EN
   assign stall = (ctrl_dec.read | ctrl_dec.write) & ~mem_done;
`else
   logic unused_mem_done;
   assign unused_mem_done = mem_done;
   assign stall           = 1'b0;
`endif

   // Next step: halt after T2 on the halt opcode, wrap (or halt on stop) at the last step.
   always_comb begin
      state_d = state_q;
      if (state_q != StHalt) begin
         if (state_q == StT2 && ir_op == OpHalt) begin
            state_d = StHalt;
         end else if (state_q == last_step(ir_op) || state_q == StT7) begin
            state_d = stop ? StHalt : StT0;
         end else begin
            state_d = cu_state_e'(4'(state_q) + 4'd1);
         end
      end
   end

   // State register; reset wins over every transition including HALT.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StT0;
      end else if (!stall) begin
         state_q <= state_d;
      end
   end

   assign PCout   = ctrl.pc_out;
   assign PCin    = ctrl.pc_in;
   assign IncPC   = ctrl.inc_pc;
   assign MARin   = ctrl.mar_in;
   assign MDRin   = ctrl.mdr_in;
   assign MDRout  = ctrl.mdr_out;
   assign IRin    = ctrl.ir_in;
   assign Read    = ctrl.read;
   assign Write   = ctrl.write;
   assign Yin     = ctrl.y_in;
   assign Zin     = ctrl.z_in;
   assign Zlowout = ctrl.zlow_out;
   assign Cout    = ctrl.c_out;
   assign BAout   = ctrl.ba_out;
   assign Gra     = ctrl.gra;
   assign Grb     = ctrl.grb;
   assign Grc     = ctrl.grc;
   assign Rin     = ctrl.r_in;
   assign Rout    = ctrl.r_out;
   assign ADD     = ctrl.alu_add;
   assign SUB     = ctrl.alu_sub;
   assign AND     = ctrl.alu_and;
   assign OR      = ctrl.alu_or;

endmodule
